jze_predictor: RTL and testbench

- Branch-direction predictor for JZE in the MicroEV20 microsequencer; the producing end of the prediction/check interface.
- Drives `aux_pred_type` and `aux_last_pred` to the JZE checker.
- Consumes the checker's `checked`, `incorrect_pred` and `correct_pred` to train a table of 2-bit saturating counters indexed by low PC bits.
- Raises a one-cycle `flush` on misprediction.

---
 rtl/jze_predictor.sv | 174 +++++++++++++++++
 tb/tb_jze_predictor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jze_predictor.sv
// JZE branch-direction predictor: 2-bit saturating counter table indexed by low PC bits.
// Optional statistics outputs pred_count/miss_count are enabled with JZE_PRED_STATS_EN.
module jze_predictor #(
  parameter int unsigned IDX_W    = 4,
  parameter logic [1:0]  CTR_INIT = 2'b01,
  parameter int unsigned MAX_WAIT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        is_jze,
  input  logic        pred_req,
  input  logic        checked,
  input  logic        incorrect_pred,
  input  logic        correct_pred,
  output logic [1:0]  aux_pred_type,
  output logic        aux_last_pred,
  output logic        flush,
  output logic        timeout,
  output logic        busy
`ifdef JZE_PRED_STATS_EN
  ,
  output logic [15:0] pred_count,
  output logic [15:0] miss_count
`endif
);

  localparam int unsigned DEPTH     = 1 << IDX_W;
  localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_CHK,
    S_UPDATE
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         ctr_q [DEPTH];
  logic [1:0]         ctr_d [DEPTH];
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic               checked_prev_q, checked_prev_d;
  logic               outcome_q, outcome_d;
  logic [1:0]         pred_type_q, pred_type_d;
  logic               last_pred_q, last_pred_d;
  logic               flush_q, flush_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;
  logic               chk_edge;
  logic [1:0]         cur_ctr;
  logic               unused_pc_hi;

  always_comb begin
    chk_edge       = checked & ~checked_prev_q;
    checked_prev_d = checked;
    cur_ctr        = ctr_q[idx_q];
    unused_pc_hi   = ^pc[15:IDX_W];

    state_d     = state_q;
    ctr_d       = ctr_q;
    idx_d       = idx_q;
    wait_cnt_d  = wait_cnt_q;
    outcome_d   = outcome_q;
    pred_type_d = pred_type_q;
    last_pred_d = last_pred_q;
    flush_d     = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pred_req) begin
          if (is_jze) begin
            last_pred_d = ctr_q[pc[IDX_W-1:0]][1];
            pred_type_d = 2'b01;
            idx_d       = pc[IDX_W-1:0];
            wait_cnt_d  = '0;
            state_d     = S_WAIT_CHK;
          end else begin
            pred_type_d = 2'b00;
          end
        end
      end
      S_WAIT_CHK: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        // A check edge in the final wait cycle takes priority over the timeout.
        if (chk_edge) begin
          outcome_d = correct_pred;
          flush_d   = incorrect_pred;
          state_d   = S_UPDATE;
        end else if (wait_cnt_d == WAIT_LAST) begin
          timeout_d   = 1'b1;
          pred_type_d = 2'b00;
          state_d     = S_IDLE;
        end
      end
      S_UPDATE: begin
        if (outcome_q) begin
          ctr_d[idx_q] = (cur_ctr == 2'b11) ? cur_ctr : cur_ctr + 2'd1;
        end else begin
          ctr_d[idx_q] = (cur_ctr == 2'b00) ? cur_ctr : cur_ctr - 2'd1;
        end
        pred_type_d = 2'b00;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      for (int unsigned i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
      idx_q          <= '0;
      wait_cnt_q     <= '0;
      checked_prev_q <= 1'b0;
      outcome_q      <= 1'b0;
      pred_type_q    <= '0;
      last_pred_q    <= 1'b0;
      flush_q        <= 1'b0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ctr_q          <= ctr_d;
      idx_q          <= idx_d;
      wait_cnt_q     <= wait_cnt_d;
      checked_prev_q <= checked_prev_d;
      outcome_q      <= outcome_d;
      pred_type_q    <= pred_type_d;
      last_pred_q    <= last_pred_d;
      flush_q        <= flush_d;
      timeout_q      <= timeout_d;
      busy_q         <= busy_d;
    end
  end

  assign aux_pred_type = pred_type_q;
  assign aux_last_pred = last_pred_q;
  assign flush         = flush_q;
  assign timeout       = timeout_q;
  assign busy          = busy_q;

`ifdef JZE_PRED_STATS_EN
  logic [15:0] pred_cnt_q, pred_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    pred_cnt_d = pred_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == S_IDLE) && pred_req && is_jze && (pred_cnt_q != '1)) begin
      pred_cnt_d = pred_cnt_q + 16'd1;
    end
    if (flush_d && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      pred_cnt_q <= pred_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign pred_count = pred_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_jze_predictor.sv
// Scoreboard bench for jze_predictor: stimulus pushes expected events, a negedge monitor pops them.
module tb_jze_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        is_jze, pred_req, checked, incorrect_pred, correct_pred;
  logic [1:0]  aux_pred_type;
  logic        aux_last_pred, flush, timeout, busy;
`ifdef JZE_PRED_STATS_EN
  logic [15:0] pred_count, miss_count;
`endif

  jze_predictor #(.IDX_W(4), .CTR_INIT(2'b01), .MAX_WAIT(32)) dut (
    .clk(clk), .reset(reset), .pc(pc), .is_jze(is_jze), .pred_req(pred_req),
    .checked(checked), .incorrect_pred(incorrect_pred), .correct_pred(correct_pred),
    .aux_pred_type(aux_pred_type), .aux_last_pred(aux_last_pred),
    .flush(flush), .timeout(timeout), .busy(busy)
`ifdef JZE_PRED_STATS_EN
    , .pred_count(pred_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef enum int {EV_PRED, EV_FLUSH, EV_TIMEOUT} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    logic     val;
  } ev_t;

  ev_t  exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   model_ctr[16];
  logic [1:0] prev_type = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each entry is a plain integer confidence in 0..3.
  function automatic logic model_pred(input int unsigned idx);
    return model_ctr[idx] >= 2;
  endfunction

  function automatic void model_train(input int unsigned idx, input logic taken);
    if (taken) model_ctr[idx] = (model_ctr[idx] + 1 > 3) ? 3 : model_ctr[idx] + 1;
    else       model_ctr[idx] = (model_ctr[idx] - 1 < 0) ? 0 : model_ctr[idx] - 1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) model_ctr[i] = 1;
  endfunction

  task automatic idle_inputs();
    pred_req = 1'b0; is_jze = 1'b0; checked = 1'b0;
    correct_pred = 1'b0; incorrect_pred = 1'b0;
  endtask

  task automatic push_ev(input ev_kind_e k, input logic v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Monitor: pops an expectation for every prediction start, flush pulse and timeout pulse.
  task automatic pop_cmp(input ev_kind_e k, input logic v);
    ev_t e;
    chk("event_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("event_kind", e.kind, k);
      if (k == EV_PRED) chk("pred_dir", v, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (aux_pred_type == 2'b01 && prev_type != 2'b01) pop_cmp(EV_PRED, aux_last_pred);
      if (flush)   pop_cmp(EV_FLUSH, 1'b0);
      if (timeout) pop_cmp(EV_TIMEOUT, 1'b0);
    end
    prev_type = aux_pred_type;
  end

  task automatic predict_and_check(input logic [15:0] a, input logic taken, input bit force_miss,
                                   input int delay, input bit poke);
    int unsigned idx;
    logic p;
    idx = a[3:0];
    @(negedge clk);
    pc = a; is_jze = 1'b1; pred_req = 1'b1;
    p = model_pred(idx);
    push_ev(EV_PRED, p);
    @(negedge clk);
    pred_req = 1'b0; is_jze = 1'b0;
    chk("busy_after_req", busy, 1);
    repeat (delay) begin
      @(negedge clk);
      pred_req = poke & 1'($urandom_range(0, 1));
      is_jze   = pred_req;
      pc       = 16'($urandom);
      correct_pred   = 1'($urandom);
      incorrect_pred = 1'($urandom);
    end
    @(negedge clk);
    pred_req = 1'b0; is_jze = 1'b0;
    checked = 1'b1; correct_pred = taken;
    incorrect_pred = force_miss | (taken != p);
    if (incorrect_pred) push_ev(EV_FLUSH, 1'b0);
    model_train(idx, taken);
    @(negedge clk);
    checked = 1'b0; correct_pred = 1'($urandom); incorrect_pred = 1'($urandom);
    @(negedge clk);
    correct_pred = 1'b0; incorrect_pred = 1'b0;
    chk("busy_after_update", busy, 0);
    chk("type_after_update", aux_pred_type, 0);
    chk("flush_one_cycle", flush, 0);
    chk("last_pred_hold", aux_last_pred, p);
  endtask

  task automatic timeout_test(input logic [15:0] a);
    int cycles;
    @(negedge clk);
    pc = a; is_jze = 1'b1; pred_req = 1'b1;
    push_ev(EV_PRED, model_pred(a[3:0]));
    push_ev(EV_TIMEOUT, 1'b0);
    @(negedge clk);
    pred_req = 1'b0; is_jze = 1'b0;
    cycles = 0;
    while (!timeout && cycles < 60) begin
      @(negedge clk);
      cycles++;
    end
    chk("timeout_latency", cycles, 31);
    chk("timeout_busy", busy, 0);
    chk("timeout_type", aux_pred_type, 0);
    @(negedge clk);
    chk("timeout_pulse_width", timeout, 0);
  endtask

  task automatic level_checked_test(input logic [15:0] a);
    logic p;
    p = model_pred(a[3:0]);
    @(negedge clk);
    pc = a; is_jze = 1'b1; pred_req = 1'b1;
    checked = 1'b1; correct_pred = ~p; incorrect_pred = 1'b1;
    push_ev(EV_PRED, p);
    @(negedge clk);
    pred_req = 1'b0; is_jze = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checked = 1'b0; incorrect_pred = 1'b0;
    @(negedge clk);
    checked = 1'b1; correct_pred = p; incorrect_pred = 1'b0;
    model_train(a[3:0], p);
    @(negedge clk);
    checked = 1'b0;
    @(negedge clk);
    chk("level_busy", busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    pc = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_type", aux_pred_type, 0);
    chk("rst_last", aux_last_pred, 0);
    chk("rst_flush", flush, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    predict_and_check(16'h0003, 1'b1, 1'b1, 0, 1'b0);
    predict_and_check(16'h0003, 1'b1, 1'b0, 2, 1'b1);
    for (int i = 0; i < 5; i++) predict_and_check(16'h0005, 1'b1, 1'b0, 1, 1'b0);
    for (int i = 0; i < 5; i++) predict_and_check(16'h0005, 1'b0, 1'b0, 1, 1'b0);

    timeout_test(16'h1235);
    predict_and_check(16'h0005, 1'b1, 1'b0, 0, 1'b0);
    level_checked_test(16'h0009);
    predict_and_check(16'h0009, 1'b1, 1'b0, 0, 1'b0);

    @(negedge clk);
    pc = 16'h0003; is_jze = 1'b0; pred_req = 1'b1;
    @(negedge clk);
    pred_req = 1'b0;
    chk("nonjze_type", aux_pred_type, 0);
    chk("nonjze_busy", busy, 0);

    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        pc = 16'($urandom); is_jze = 1'b0; pred_req = 1'b1;
        @(negedge clk);
        pred_req = 1'b0;
        chk("rand_nonjze_busy", busy, 0);
      end else begin
        logic [15:0] a;
        a = 16'($urandom);
        a[3:0] = 4'($urandom_range(0, 5));
        predict_and_check(a, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 15) == 0,
                          int'($urandom_range(0, 6)), 1'($urandom));
      end
    end

    // Async reset while a prediction waits for its check.
    predict_and_check(16'h0007, 1'b1, 1'b0, 0, 1'b0);
    predict_and_check(16'h0007, 1'b1, 1'b0, 0, 1'b0);
    @(negedge clk);
    pc = 16'h0007; is_jze = 1'b1; pred_req = 1'b1;
    push_ev(EV_PRED, model_pred(7));
    @(negedge clk);
    pred_req = 1'b0; is_jze = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_type", aux_pred_type, 0);
    chk("async_rst_last", aux_last_pred, 0);
    chk("async_rst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    predict_and_check(16'h0007, 1'b1, 1'b0, 0, 1'b0);

    // Async reset cancels a pending flush.
    @(negedge clk);
    pc = 16'h0002; is_jze = 1'b1; pred_req = 1'b1;
    push_ev(EV_PRED, model_pred(2));
    @(negedge clk);
    pred_req = 1'b0; is_jze = 1'b0;
    @(negedge clk);
    checked = 1'b1; correct_pred = 1'b1; incorrect_pred = 1'b1;
    push_ev(EV_FLUSH, 1'b0);
    @(negedge clk);
    checked = 1'b0; incorrect_pred = 1'b0;
    chk("flush_seen", flush, 1);
    #2 reset = 1'b1;
    #1;
    chk("flush_cancel", flush, 0);
    chk("flush_cancel_busy", busy, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    predict_and_check(16'h0002, 1'b0, 1'b0, 1, 1'b0);
    predict_and_check(16'h0002, 1'b1, 1'b0, 1, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
